// File: rtl/telemetry_frame_sequencer.sv
// Telemetry frame sequencer: while tx_enable is high, emits one frame
// (sync, frame count, payload snapshot, checksum) every FRAME_PERIOD clocks to a UART.
module telemetry_frame_sequencer #(
    parameter int unsigned FRAME_PERIOD  = 4800000,
    parameter int unsigned PAYLOAD_BYTES = 8,
    parameter logic [15:0] SYNC_WORD     = 16'hEB90
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tx_enable,
    input  logic [8*PAYLOAD_BYTES-1:0] payload_data,
    input  logic                       uart_ready,
    output logic [7:0]                 uart_data,
    output logic                       uart_valid,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun,
    output logic [15:0]                frame_count
);

    localparam int unsigned PW    = 8 * PAYLOAD_BYTES;
    localparam int unsigned CNT_W = $clog2(FRAME_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);
    // Byte index of the checksum, the final byte of the frame.
    localparam logic [5:0] IDX_LAST = 6'(4 + PAYLOAD_BYTES);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_t;

    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic             pending;
    logic [PW-1:0]    payload_snap;
    logic [15:0]      count_snap;
    logic [7:0]       csum;
    logic [5:0]       idx;

    logic             start_req;
    logic [5:0]       nxt_idx;
    logic [7:0]       nxt_payload;
    logic [7:0]       nxt_byte;

    assign start_req = tx_enable && (period_cnt == '0);

    always_comb begin
        nxt_idx     = idx + 6'd1;
        nxt_payload = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (nxt_idx == 6'(i + 4)) begin
                nxt_payload = payload_snap[PW-1-8*i -: 8];
            end
        end
        nxt_byte = nxt_payload;
        if (nxt_idx == 6'd1) begin
            nxt_byte = SYNC_WORD[7:0];
        end else if (nxt_idx == 6'd2) begin
            nxt_byte = count_snap[15:8];
        end else if (nxt_idx == 6'd3) begin
            nxt_byte = count_snap[7:0];
        end else if (nxt_idx == IDX_LAST) begin
            // The byte being accepted now is the last summed byte.
            nxt_byte = csum + uart_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            period_cnt   <= '0;
            pending      <= 1'b0;
            payload_snap <= '0;
            count_snap   <= 16'h0000;
            csum         <= 8'h00;
            idx          <= 6'd0;
            uart_data    <= 8'h00;
            uart_valid   <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            frame_count  <= 16'h0000;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;

            if (!tx_enable || period_cnt == CNT_LAST) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + CNT_W'(1);
            end

            unique case (state)
                StIdle: begin
                    if (tx_enable && (start_req || pending)) begin
                        state   <= StLoad;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                StLoad: begin
                    payload_snap <= payload_data;
                    count_snap   <= frame_count;
                    csum         <= 8'h00;
                    idx          <= 6'd0;
                    uart_data    <= SYNC_WORD[15:8];
                    uart_valid   <= 1'b1;
                    state        <= StSend;
                end
                StSend: begin
                    if (uart_ready) begin
                        if (idx == IDX_LAST) begin
                            uart_valid  <= 1'b0;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            state       <= StDone;
                        end else begin
                            idx       <= nxt_idx;
                            uart_data <= nxt_byte;
                            if (idx >= 6'd2) begin
                                csum <= csum + uart_data;
                            end
                        end
                    end
                end
                StDone: begin
                    if (tx_enable && (start_req || pending)) begin
                        state <= StLoad;
                        busy  <= 1'b1;
                    end else begin
                        state <= StIdle;
                    end
                    pending <= 1'b0;
                end
                default: state <= StIdle;
            endcase

            // Extra requests while a frame is in flight collapse into one pending bit.
            if ((state == StLoad || state == StSend) && start_req) begin
                pending <= 1'b1;
                overrun <= 1'b1;
            end
            if (!tx_enable) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_telemetry_frame_sequencer.sv
// Bench for telemetry_frame_sequencer: queue-based frame model checked every cycle,
// plus literal byte sequences for known payloads.
module tb_telemetry_frame_sequencer;

    localparam int unsigned PERIOD = 16;
    localparam int unsigned PB     = 2;
    localparam int unsigned PW     = 8 * PB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tx_enable = 1'b0;
    logic          uart_ready = 1'b0;
    logic [PW-1:0] payload_data = '0;
    logic [7:0]    uart_data;
    logic          uart_valid;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic [15:0]   frame_count;

    telemetry_frame_sequencer #(
        .FRAME_PERIOD (PERIOD),
        .PAYLOAD_BYTES(PB),
        .SYNC_WORD    (16'hEB90)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_enable   (tx_enable),
        .payload_data(payload_data),
        .uart_ready  (uart_ready),
        .uart_data   (uart_data),
        .uart_valid  (uart_valid),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: bytes still to send for the frame in flight, plus a few flags.
    int           m_cnt;
    bit           m_pend;
    bit           m_load;
    bit           m_done;
    bit           m_ov;
    int           m_count;
    logic [7:0]   q[$];
    logic [7:0]   log_q[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_pend  = 1'b0;
        m_load  = 1'b0;
        m_done  = 1'b0;
        m_ov    = 1'b0;
        m_count = 0;
        q.delete();
    endtask

    task automatic model_step(input bit te, input bit rdy, input logic [PW-1:0] pay);
        bit         req;
        logic [7:0] sum;
        logic [7:0] b;
        req  = te && (m_cnt == 0);
        m_ov = 1'b0;
        if (m_load) begin
            m_load = 1'b0;
            q.delete();
            q.push_back(8'hEB);
            q.push_back(8'h90);
            q.push_back(8'(m_count >> 8));
            q.push_back(8'(m_count));
            sum = 8'(m_count >> 8) + 8'(m_count);
            for (int i = 0; i < PB; i++) begin
                b = pay[PW-1-8*i -: 8];
                q.push_back(b);
                sum = sum + b;
            end
            q.push_back(sum);
            if (req) begin
                m_pend = 1'b1;
                m_ov   = 1'b1;
            end
        end else if (q.size() > 0) begin
            if (req) begin
                m_pend = 1'b1;
                m_ov   = 1'b1;
            end
            if (rdy) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_done  = 1'b1;
                    m_count = (m_count + 1) % 65536;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
            if (te && (m_pend || req)) m_load = 1'b1;
            m_pend = 1'b0;
        end else if (te && (req || m_pend)) begin
            m_load = 1'b1;
            m_pend = 1'b0;
        end
        if (!te) m_pend = 1'b0;
        m_cnt = te ? (m_cnt + 1) % PERIOD : 0;
    endtask

    task automatic check_outputs();
        cmp("uart_valid", 32'(uart_valid), 32'(q.size() > 0));
        if (q.size() > 0) cmp("uart_data", 32'(uart_data), 32'(q[0]));
        cmp("busy", 32'(busy), 32'(m_load || q.size() > 0));
        cmp("frame_done", 32'(frame_done), 32'(m_done));
        cmp("overrun", 32'(overrun), 32'(m_ov));
        cmp("frame_count", 32'(frame_count), 32'(m_count));
    endtask

    task automatic cycle(input bit te, input bit rdy, input logic [PW-1:0] pay);
        @(negedge clk);
        check_outputs();
        tx_enable    = te;
        uart_ready   = rdy;
        payload_data = pay;
        if (uart_valid && rdy) log_q.push_back(uart_data);
        if (reset) model_step(te, rdy, pay);
        else model_reset();
    endtask

    // Assert reset between clock edges and check that it takes effect at once.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        cmp("rst_uart_valid", 32'(uart_valid), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_frame_count", 32'(frame_count), 32'd0);
        model_reset();
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        reset = 1'b1;
    endtask

    task automatic check_log(input string name, input int idx, input logic [7:0] exp);
        cmp(name, (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    logic [7:0] exp_two[14] = '{8'hEB, 8'h90, 8'h00, 8'h00, 8'h12, 8'h34, 8'h46,
                                8'hEB, 8'h90, 8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
    logic [7:0] exp_rst[7] = '{8'hEB, 8'h90, 8'h00, 8'h00, 8'hA5, 8'hC3, 8'h68};

    initial begin
        bit          te;
        bit          rdy;
        int unsigned mode;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) cycle(1'b0, 1'b1, 16'h1234);
        reset = 1'b1;

        // Two back-to-back periods with a fixed payload.
        log_q.delete();
        repeat (12) cycle(1'b1, 1'b1, 16'h1234);
        cmp("count_after_first", 32'(frame_count), 32'd1);
        repeat (28) cycle(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 14; i++) check_log($sformatf("frame_byte%0d", i), i, exp_two[i]);

        // Slow UART: one ready cycle in four, payload changing every cycle.
        for (int i = 0; i < 80; i++) cycle(1'b1, (i % 4) == 0, PW'($urandom));

        // Window closes mid-frame, then idles.
        repeat (20) cycle(1'b0, 1'b1, PW'($urandom));

        // Reset in the middle of a frame, then a fresh frame from count zero.
        repeat (5) cycle(1'b1, 1'b1, 16'hA5C3);
        async_reset();
        log_q.delete();
        repeat (15) cycle(1'b1, 1'b1, 16'hA5C3);
        for (int i = 0; i < 7; i++) check_log($sformatf("post_reset_byte%0d", i), i, exp_rst[i]);
        cmp("count_post_reset", 32'(frame_count), 32'd1);

        // Randomized window, ready patterns and occasional resets.
        te   = 1'b1;
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) te = ~te;
            if (i % 50 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = ($urandom_range(0, 9) == 0);
            endcase
            cycle(te, rdy, PW'($urandom));
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
